bcd2bin_16: RTL and testbench
=============================

BCD2BIN_16 -- requirements
Module: bcd2bin_16

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk only.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request, sampled on clk edges.
REQ-005 BCD_0  input  4  decimal units digit (least significant).
REQ-006 BCD_1  input  4  tens digit.
REQ-007 BCD_2  input  4  hundreds digit.
REQ-008 BCD_3  input  4  thousands digit.
REQ-009 BCD_4  input  4  ten-thousands digit (most significant).
REQ-010 bin  output  16  binary result, registered.
REQ-011 done  output  1  one-cycle pulse marking that bin/ovf/err are updated.
REQ-012 busy  output  1  high while a conversion is in progress.
REQ-013 ovf  output  1  the decimal value exceeded 65535.
REQ-014 err  output  1  a digit greater than 9 was captured.

Function
REQ-015 The block SHALL have two states, IDLE and CONV; the reset state SHALL be IDLE.
REQ-016 In IDLE with start=1 at edge N, the block SHALL capture all five digits and clear the 17-bit accumulator acc to 0.
REQ-017 At the same edge N, the block SHALL set digit index idx=4, set busy=1, enter CONV, and record invalid=1 if any captured digit is greater than 9.
REQ-018 In CONV, each edge SHALL perform acc = acc*10 + digit[idx] and then decrement idx; acc*10 SHALL be formed as (acc<<3)+(acc<<1) in 17 bits with no multiplier.
REQ-019 The fifth CONV edge (edge N+5) SHALL load the outputs, pulse done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-020 Latency SHALL be 5 clocks from the accepting start edge to done high, with bin valid in the same cycle that done is high.
REQ-021 At edge N+5, if invalid=1 the block SHALL set err=1, ovf=0 and bin=16'h0000.
REQ-022 At edge N+5, if invalid=0 and the final acc is greater than 65535, the block SHALL set ovf=1, err=0 and bin=16'hFFFF (saturated).
REQ-023 At edge N+5, in all other cases the block SHALL set bin=acc[15:0], ovf=0 and err=0.
REQ-024 bin, ovf and err SHALL hold their values until the next done; done SHALL be 0 in every other cycle.
REQ-025 start SHALL be ignored while busy=1, including at edge N+5.
REQ-026 Digit inputs SHALL be don't-care after the capture edge N; changing them during CONV SHALL NOT affect the result.
REQ-027 Back-to-back operation: start=1 in the cycle in which done=1 SHALL be accepted at that edge (edge N+6), giving a sustained rate of one conversion per 6 clocks.
REQ-028 If start is held high continuously, the block SHALL restart a conversion each time it enters IDLE.
REQ-029 The maximum legal input 99999 fits in 17 bits, so acc SHALL NOT wrap under any valid digit set.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, bin=0, done=0, busy=0, ovf=0, err=0, acc=0 and idx=0.
REQ-031 Reset asserted mid-conversion SHALL abort the conversion; no done pulse SHALL appear for the aborted request.
REQ-032 The first start accepted after rst_n rises SHALL convert normally.

Verification
REQ-033 Digits 1,2,3,4,5 (BCD_4..BCD_0) with a 1-cycle start: the bench SHALL see busy=1 for 5 cycles, then done=1 with bin=16'h3039, ovf=0, err=0.
REQ-034 Input 65535: the bench SHALL see bin=16'hFFFF, ovf=0. Input 70000: the bench SHALL see bin=16'hFFFF, ovf=1. Input 00000: the bench SHALL see bin=16'h0000.
REQ-035 Input with BCD_2=4'hA: the bench SHALL see done with err=1, bin=16'h0000, ovf=0.
REQ-036 rst_n pulsed low at edge N+3: the bench SHALL see busy drop asynchronously, no done, all outputs 0; a following conversion of 00042 SHALL give bin=16'h002A.
REQ-037 Start held high with inputs 00001 then 09999: the bench SHALL see done every 6 cycles, bin=16'h0001 then 16'h270F, and digit changes during CONV SHALL have no effect.
REQ-038 Start pulsed during CONV: the bench SHALL see it ignored, with only one done pulse per accepted request.

Source files
------------

// File: rtl/bcd2bin_16.sv
// Five-digit BCD to 16-bit binary converter: one digit per clock, MSD first,
// with saturation on overflow and an error flag for non-decimal digits.
module bcd2bin_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  BCD_0,
    input  logic [3:0]  BCD_1,
    input  logic [3:0]  BCD_2,
    input  logic [3:0]  BCD_3,
    input  logic [3:0]  BCD_4,
    output logic [15:0] bin,
    output logic        done,
    output logic        busy,
    output logic        ovf,
    output logic        err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [0:0]  r_state;
    logic [16:0] r_acc;
    logic [2:0]  r_idx;
    logic [3:0]  r_d0, r_d1, r_d2, r_d3, r_d4;
    logic        r_invalid;
    logic [15:0] r_bin;
    logic        r_done;
    logic        r_busy;
    logic        r_ovf;
    logic        r_err;

    logic [3:0]  w_digit;
    logic [16:0] w_acc_next;
    logic        w_any_invalid;
    logic        w_last;

    always_comb begin
        w_digit = r_d0;
        case (r_idx)
            3'd4:    w_digit = r_d4;
            3'd3:    w_digit = r_d3;
            3'd2:    w_digit = r_d2;
            3'd1:    w_digit = r_d1;
            default: w_digit = r_d0;
        endcase
    end

    // acc*10 built from shifts; 99999 is the largest reachable value, so 17 bits never wrap
    assign w_acc_next    = (r_acc << 3) + (r_acc << 1) + {13'd0, w_digit};
    assign w_any_invalid = (BCD_0 > 4'd9) || (BCD_1 > 4'd9) || (BCD_2 > 4'd9) ||
                           (BCD_3 > 4'd9) || (BCD_4 > 4'd9);
    assign w_last        = (r_idx == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_idx     <= '0;
            r_d0      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_d4      <= '0;
            r_invalid <= 1'b0;
            r_bin     <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_d0      <= BCD_0;
                        r_d1      <= BCD_1;
                        r_d2      <= BCD_2;
                        r_d3      <= BCD_3;
                        r_d4      <= BCD_4;
                        r_invalid <= w_any_invalid;
                        r_acc     <= '0;
                        r_idx     <= 3'd4;
                        r_busy    <= 1'b1;
                        r_state   <= CONV;
                    end
                end
                CONV: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                        if (r_invalid) begin
                            r_bin <= '0;
                            r_ovf <= 1'b0;
                            r_err <= 1'b1;
                        end else if (w_acc_next[16]) begin
                            r_bin <= '1;
                            r_ovf <= 1'b1;
                            r_err <= 1'b0;
                        end else begin
                            r_bin <= w_acc_next[15:0];
                            r_ovf <= 1'b0;
                            r_err <= 1'b0;
                        end
                    end else begin
                        r_idx <= r_idx - 3'd1;
                    end
                end
            endcase
        end
    end

    assign bin  = r_bin;
    assign done = r_done;
    assign busy = r_busy;
    assign ovf  = r_ovf;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd2bin_16.sv
// Directed bench for bcd2bin_16: conversions, saturation, error digits,
// mid-conversion reset, held start and start-while-busy.
module tb_bcd2bin_16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  BCD_0, BCD_1, BCD_2, BCD_3, BCD_4;
    logic [15:0] bin;
    logic        done, busy, ovf, err;

    int checks = 0;
    int errors = 0;

    bcd2bin_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .BCD_0 (BCD_0),
        .BCD_1 (BCD_1),
        .BCD_2 (BCD_2),
        .BCD_3 (BCD_3),
        .BCD_4 (BCD_4),
        .bin   (bin),
        .done  (done),
        .busy  (busy),
        .ovf   (ovf),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_digits(input logic [3:0] d4, d3, d2, d1, d0);
        BCD_4 = d4; BCD_3 = d3; BCD_2 = d2; BCD_1 = d1; BCD_0 = d0;
    endtask

    task automatic scramble();
        BCD_4 = 4'($urandom_range(15)); BCD_3 = 4'($urandom_range(15));
        BCD_2 = 4'($urandom_range(15)); BCD_1 = 4'($urandom_range(15));
        BCD_0 = 4'($urandom_range(15));
    endtask

    // 1-cycle start; digits are scrambled during CONV since they are don't-care there
    task automatic run_conv(input string tag, input logic [3:0] d4, d3, d2, d1, d0,
                            input logic [15:0] eb, input logic eo, input logic ee);
        set_digits(d4, d3, d2, d1, d0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            scramble();
            tick();
        end
        chk({tag, "_busy5"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_bin"}, {16'd0, bin}, {16'd0, eb});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
        tick();
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        tick();
        chk({tag, "_hold"}, {16'd0, bin}, {16'd0, eb});
    endtask

    initial begin
        int seen;
        rst_n = 1'b1;
        start = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bin", {16'd0, bin}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_conv("c12345", 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 16'h3039, 1'b0, 1'b0);
        run_conv("c65535", 4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 16'hFFFF, 1'b0, 1'b0);
        run_conv("c70000", 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b0);
        run_conv("c00000", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0);
        run_conv("c99999", 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 16'hFFFF, 1'b1, 1'b0);
        run_conv("c65536", 4'd6, 4'd5, 4'd5, 4'd3, 4'd6, 16'hFFFF, 1'b1, 1'b0);
        run_conv("cbadA", 4'd0, 4'd0, 4'hA, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1);

        // Reset asserted just before edge N+3 of a conversion
        set_digits(4'd5, 4'd4, 4'd3, 4'd2, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #6 rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_bin", {16'd0, bin}, 32'd0);
        chk("mrst_ovf", {31'd0, ovf}, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        chk("mrst_nodone", seen, 0);
        run_conv("c00042", 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 16'h002A, 1'b0, 1'b0);

        // Start held high: back-to-back conversions every 6 clocks
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd1);
        start = 1'b1;
        tick();
        chk("held_busy", {31'd0, busy}, 32'd1);
        set_digits(4'd0, 4'd9, 4'd9, 4'd9, 4'd9);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_nodone1", {31'd0, done}, 32'd0);
        end
        tick();
        chk("held_done1", {31'd0, done}, 32'd1);
        chk("held_bin1", {16'd0, bin}, 32'h0001);
        tick();
        chk("held_restart", {31'd0, busy}, 32'd1);
        chk("held_pulse", {31'd0, done}, 32'd0);
        set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_nodone2", {31'd0, done}, 32'd0);
        end
        tick();
        chk("held_done2", {31'd0, done}, 32'd1);
        chk("held_bin2", {16'd0, bin}, 32'h270F);
        chk("held_ovf2", {31'd0, ovf}, 32'd0);
        tick();
        chk("held_end", {31'd0, busy}, 32'd0);

        // Start pulsed while busy, including across the final CONV edge
        set_digits(4'd0, 4'd0, 4'd1, 4'd2, 4'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        tick();
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_bin", {16'd0, bin}, 32'h007B);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("ign_single", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
